// File: rtl/ex_stage_mdu.sv
// EX stage: operand forwarding, ALU, EX/MEM register and an iterative MUL/DIV unit with HI/LO.
// Latency: ALU result 1 cycle to M; MUL/DIV busy DW cycles (define MDU_FAST_MUL_EN for 1-cycle multiply).
// Backpressure: StallE holds IF/ID/EX while an MDU op or HI/LO read waits on a busy MDU.
module ex_stage_mdu #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic          ALUSrcE,
  input  logic          RegDstE,
  input  logic          FlushE,
  input  logic [1:0]    ForwardAE,
  input  logic [1:0]    ForwardBE,
  input  logic [3:0]    ALUControlE,
  input  logic [2:0]    MduOpE,
  input  logic [RW-1:0] RsE,
  input  logic [RW-1:0] RtE,
  input  logic [RW-1:0] RdE,
  input  logic [SW-1:0] shamtE,
  input  logic [DW-1:0] RD1E,
  input  logic [DW-1:0] RD2E,
  input  logic [DW-1:0] SignImmE,
  input  logic [DW-1:0] ResultW,
  output logic          StallE,
  output logic          MduBusy,
  output logic [RW-1:0] WriteRegE,
  output logic          RegWriteM,
  output logic          MemtoRegM,
  output logic          MemWriteM,
  output logic [RW-1:0] WriteRegM,
  output logic [DW-1:0] ALUOutM,
  output logic [DW-1:0] WriteDataM
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] srcA, srcB, writeDataE, aluOut;
  logic [DW-1:0] hiReg, loReg;

  // RsE is consumed by the hazard unit, not here
  logic unusedRs;
  assign unusedRs = ^RsE;

  always_comb begin
    srcA = RD1E;
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUOutM;
      default: srcA = RD1E;
    endcase
    writeDataE = RD2E;
    case (ForwardBE)
      2'b01:   writeDataE = ResultW;
      2'b10:   writeDataE = ALUOutM;
      default: writeDataE = RD2E;
    endcase
    srcB = ALUSrcE ? SignImmE : writeDataE;
  end

  assign WriteRegE = RegDstE ? RdE : RtE;

  always_comb begin
    aluOut = '0;
    case (ALUControlE)
      4'b0000: aluOut = srcA & srcB;
      4'b0001: aluOut = srcA | srcB;
      4'b0010: aluOut = srcA + srcB;
      4'b0110: aluOut = srcA - srcB;
      4'b1000: aluOut = srcA ^ srcB;
      4'b1001: aluOut = ~(srcA | srcB);
      4'b0111: aluOut = {{(DW-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'b1010: aluOut = {{(DW-1){1'b0}}, srcA < srcB};
      4'b0011: aluOut = srcB << shamtE;
      4'b0100: aluOut = srcB >> shamtE;
      4'b0101: aluOut = $signed(srcB) >>> shamtE;
      4'b1100: aluOut = hiReg;
      4'b1101: aluOut = loReg;
      default: aluOut = '0;
    endcase
  end

  // MDU op decode
  logic mulOp, divOp, mduAny, mfOp, canIssue, signedOp, startIter;
  assign mulOp    = (MduOpE == 3'b001) | (MduOpE == 3'b010);
  assign divOp    = (MduOpE == 3'b011) | (MduOpE == 3'b100);
  assign signedOp = (MduOpE == 3'b001) | (MduOpE == 3'b011);
  assign mduAny   = (MduOpE != 3'b000) & (MduOpE != 3'b111);
  assign mfOp     = (ALUControlE == 4'b1100) | (ALUControlE == 4'b1101);
  assign canIssue = ~MduBusy & ~FlushE;
  assign StallE   = MduBusy & ~FlushE & (mduAny | mfOp);

`ifdef MDU_FAST_MUL_EN
  logic            fastMul;
  logic [2*DW-1:0] fastProd;
  assign fastMul   = canIssue & mulOp;
  assign startIter = canIssue & divOp;
  assign fastProd  = signedOp ?
      ($signed({{DW{srcA[DW-1]}}, srcA}) * $signed({{DW{writeDataE[DW-1]}}, writeDataE})) :
      ({{DW{1'b0}}, srcA} * {{DW{1'b0}}, writeDataE});
`else
  assign startIter = canIssue & (mulOp | divOp);
`endif

  // Iteration runs on magnitudes; signs are reapplied when the result is committed
  logic          aNeg, bNeg;
  logic [DW-1:0] aMag, bMag;
  assign aNeg = signedOp & srcA[DW-1];
  assign bNeg = signedOp & writeDataE[DW-1];
  assign aMag = aNeg ? -srcA : srcA;
  assign bMag = bNeg ? -writeDataE : writeDataE;

  logic [CW-1:0]   cnt;
  logic            opDiv, negQ, negR, divZero;
  logic [DW-1:0]   dividendReg, opB, accHi, accLo;
  logic [DW-1:0]   nxtHi, nxtLo, resHi, resLo;
  logic [DW:0]     mulSum, remSh, trial;
  logic [2*DW-1:0] prodAbs, prodRes;

  // One shift-add (multiply) or restoring-subtract (divide) step per busy cycle
  always_comb begin
    nxtHi  = accHi;
    nxtLo  = accLo;
    mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    remSh  = {accHi, accLo[DW-1]};
    trial  = remSh - {1'b0, opB};
    if (opDiv) begin
      if (!trial[DW]) begin
        nxtHi = trial[DW-1:0];
        nxtLo = {accLo[DW-2:0], 1'b1};
      end else begin
        nxtHi = remSh[DW-1:0];
        nxtLo = {accLo[DW-2:0], 1'b0};
      end
    end else begin
      nxtHi = mulSum[DW:1];
      nxtLo = {mulSum[0], accLo[DW-1:1]};
    end
  end

  always_comb begin
    prodAbs = {nxtHi, nxtLo};
    prodRes = negQ ? -prodAbs : prodAbs;
    resHi   = prodRes[2*DW-1:DW];
    resLo   = prodRes[DW-1:0];
    if (opDiv) begin
      if (divZero) begin
        resHi = dividendReg;
        resLo = '1;
      end else begin
        resHi = negR ? -nxtHi : nxtHi;
        resLo = negQ ? -nxtLo : nxtLo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MduBusy     <= 1'b0;
      cnt         <= '0;
      opDiv       <= 1'b0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      divZero     <= 1'b0;
      dividendReg <= '0;
      opB         <= '0;
      accHi       <= '0;
      accLo       <= '0;
      hiReg       <= '0;
      loReg       <= '0;
    end else if (MduBusy) begin
      accHi <= nxtHi;
      accLo <= nxtLo;
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(DW-1)) begin
        MduBusy <= 1'b0;
        hiReg   <= resHi;
        loReg   <= resLo;
      end
    end else if (startIter) begin
      MduBusy     <= 1'b1;
      cnt         <= '0;
      opDiv       <= divOp;
      negQ        <= aNeg ^ bNeg;
      negR        <= aNeg;
      divZero     <= (writeDataE == '0);
      dividendReg <= srcA;
      opB         <= bMag;
      accHi       <= '0;
      accLo       <= aMag;
    end
`ifdef MDU_FAST_MUL_EN
    else if (fastMul) begin
      hiReg <= fastProd[2*DW-1:DW];
      loReg <= fastProd[DW-1:0];
    end
`endif
    else if (canIssue && MduOpE == 3'b101) begin
      hiReg <= srcA;
    end else if (canIssue && MduOpE == 3'b110) begin
      loReg <= srcA;
    end
  end

  // EX/MEM register; a flushed or stalled instruction leaves as a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      WriteRegM  <= '0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
    end else begin
      RegWriteM  <= RegWriteE & ~(FlushE | StallE);
      MemtoRegM  <= MemtoRegE & ~(FlushE | StallE);
      MemWriteM  <= MemWriteE & ~(FlushE | StallE);
      WriteRegM  <= WriteRegE;
      ALUOutM    <= aluOut;
      WriteDataM <= writeDataE;
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: directed steps plus random ALU/MDU traffic against an arithmetic reference model.
module tb_ex_stage_mdu;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 5;

  logic          clk, reset_n;
  logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [3:0]    ALUControlE;
  logic [2:0]    MduOpE;
  logic [RW-1:0] RsE, RtE, RdE, WriteRegE, WriteRegM;
  logic [SW-1:0] shamtE;
  logic [DW-1:0] RD1E, RD2E, SignImmE, ResultW, ALUOutM, WriteDataM;
  logic          StallE, MduBusy, RegWriteM, MemtoRegM, MemWriteM;

  ex_stage_mdu #(.DW(DW), .RW(RW), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUControlE(ALUControlE), .MduOpE(MduOpE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .shamtE(shamtE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .ResultW(ResultW),
    .StallE(StallE), .MduBusy(MduBusy), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;
  logic [31:0] hiM, loM, prevAlu, pendHi, pendLo;
  logic        prevValid, pendValid;
  int          pendDur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fwdRef(input logic [1:0] f, input logic [31:0] rd);
    if (f == 2'b01) return ResultW;
    if (f == 2'b10) return prevAlu;
    return rd;
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd8:  return a ^ b;
      4'd9:  return ~(a | b);
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd3:  return b << sh;
      4'd4:  return b >> sh;
      4'd5:  return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd12: return hiM;
      4'd13: return loM;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mduRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = 64'd0;
    case (op)
      3'd1: p = sa * sb;
      3'd2: p = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd4: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: p = 64'd0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endtask

  function automatic int durOf(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
    if (op == 3'd1 || op == 3'd2) return 0;
`endif
    return (op == 3'd0) ? 0 : DW;
  endfunction

  task automatic idle;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0; FlushE = 0;
    ForwardAE = 0; ForwardBE = 0; ALUControlE = 4'b0010; MduOpE = 0; shamtE = 0;
  endtask

  // One non-stalled instruction through EX, checked at EX and at M
  task automatic stepCheck(input string tag);
    logic [31:0] a, wd, b, res;
    logic [4:0]  wr;
    logic        fl;
    logic [2:0]  ctl;
    #1;
    a   = fwdRef(ForwardAE, RD1E);
    wd  = fwdRef(ForwardBE, RD2E);
    b   = ALUSrcE ? SignImmE : wd;
    res = aluRef(ALUControlE, a, b, shamtE);
    wr  = RegDstE ? RdE : RtE;
    fl  = FlushE;
    ctl = fl ? 3'b000 : {RegWriteE, MemtoRegE, MemWriteE};
    check({tag, ".wregE"}, 32'(WriteRegE), 32'(wr));
    check({tag, ".stall"}, 32'(StallE), 32'd0);
    tick;
    check({tag, ".ctlM"}, 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'(ctl));
    if (ctl != 3'b000) begin
      check({tag, ".aluM"}, ALUOutM, res);
      check({tag, ".wdatM"}, WriteDataM, wd);
      check({tag, ".wregM"}, 32'(WriteRegM), 32'(wr));
    end
    if (!fl && MduOpE == 3'd5) hiM = a;
    if (!fl && MduOpE == 3'd6) loM = a;
    prevAlu   = res;
    prevValid = !fl;
  endtask

  // Hold the current EX instruction until the stall clears; count stalled cycles
  task automatic waitFree(input string tag);
    int stalls, bad, expS;
    stalls = 0;
    bad    = 0;
    expS   = pendValid ? pendDur : 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (StallE !== 1'b1) break;
      if (MduBusy !== 1'b1) bad++;
      stalls++;
      tick;
      if ({RegWriteM, MemtoRegM, MemWriteM} !== 3'b000) bad++;
    end
    check({tag, ".stalls"}, 32'(stalls), 32'(expS));
    check({tag, ".bubbles"}, 32'(bad), 32'd0);
    if (pendValid) begin
      hiM = pendHi;
      loM = pendLo;
      pendValid = 0;
    end
    if (stalls > 0) prevValid = 0;
  endtask

  task automatic mduIssue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    MduOpE = op; RD1E = a; RD2E = b; RegWriteE = 1; RtE = 5'($urandom);
    waitFree(tag);
    stepCheck(tag);
    mduRef(op, a, b, pendHi, pendLo);
    pendDur = durOf(op);
    if (pendDur == 0) begin
      hiM = pendHi;
      loM = pendLo;
      pendValid = 0;
    end else pendValid = 1;
  endtask

  task automatic mtIssue(input string tag, input logic hiSel, input logic [31:0] v);
    idle();
    MduOpE = hiSel ? 3'd5 : 3'd6; RD1E = v;
    waitFree(tag);
    stepCheck(tag);
  endtask

  task automatic mfCheck(input string tag, input logic hiSel);
    idle();
    ALUControlE = hiSel ? 4'hC : 4'hD; RegWriteE = 1; RegDstE = 1; RdE = 5'($urandom);
    waitFree(tag);
    stepCheck(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    clk = 0; reset_n = 1;
    idle();
    RsE = 0; RtE = 0; RdE = 0; RD1E = 0; RD2E = 0; SignImmE = 0; ResultW = 0;
    hiM = 0; loM = 0; prevAlu = 0; prevValid = 1; pendValid = 0; pendDur = 0; pendHi = 0; pendLo = 0;

    #1 reset_n = 0;
    #10;
    check("rst.ctlM", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'd0);
    check("rst.aluM", ALUOutM, 32'd0);
    check("rst.wdatM", WriteDataM, 32'd0);
    check("rst.wregM", 32'(WriteRegM), 32'd0);
    check("rst.busy", 32'(MduBusy), 32'd0);
    reset_n = 1;

    // Forwarding
    idle(); RegWriteE = 1; ALUSrcE = 1; RD1E = 32'h10; SignImmE = 0; stepCheck("seed");
    ForwardAE = 2'b10; RD1E = 32'h99; SignImmE = 4; stepCheck("fwd10");
    ForwardAE = 2'b11; stepCheck("fwd11");
    ForwardAE = 2'b01; ResultW = 32'h1000; stepCheck("fwd01");

    // Shift and compare corners
    ForwardAE = 0; ALUControlE = 4'b0101; SignImmE = 32'h80000000; shamtE = 4; stepCheck("sra");
    ALUSrcE = 0; shamtE = 0; RD1E = 1; RD2E = 32'hFFFFFFFF; ALUControlE = 4'b1010; stepCheck("sltu");
    ALUControlE = 4'b0111; stepCheck("slt");

    // Multiply / divide with dependent HI/LO reads held in EX
    mduIssue("mult", 3'd1, 32'hFFFFFFFD, 32'd7);
    mfCheck("mult.lo", 0); mfCheck("mult.hi", 1);
    mduIssue("div", 3'd3, 32'hFFFFFFF9, 32'd2);
    mfCheck("div.lo", 0); mfCheck("div.hi", 1);
    mduIssue("divu0", 3'd4, 32'd5, 32'd0);
    mfCheck("divu0.lo", 0); mfCheck("divu0.hi", 1);

    // Back-to-back ops: the second is accepted the cycle busy drops
    mduIssue("b2b1", 3'd4, 32'd100, 32'd7);
    mduIssue("b2b2", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    mfCheck("b2b.lo", 0); mfCheck("b2b.hi", 1);

    // MTHI behind a busy multiply
    mduIssue("mtbusy", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    mtIssue("mthi", 1, 32'h1234);
    mfCheck("mtbusy.hi", 1); mfCheck("mtbusy.lo", 0);

    // Flush during a running divide leaves it untouched
    mduIssue("flbusy", 3'd3, 32'd1000, 32'hFFFFFFF7);
    idle(); FlushE = 1; MduOpE = 3'd3; RD1E = 77; RD2E = 5; RegWriteE = 1;
    #1;
    check("flbusy.stall", 32'(StallE), 32'd0);
    check("flbusy.busy", 32'(MduBusy), 32'd1);
    tick;
    check("flbusy.ctlM", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'd0);
    pendDur = pendDur - 1;
    prevValid = 0;
    mfCheck("flbusy.lo", 0); mfCheck("flbusy.hi", 1);

    // Flushed DIV while idle must not start
    idle(); FlushE = 1; MemWriteE = 1; MduOpE = 3'd3; RD1E = 100; RD2E = 3; stepCheck("flnb");
    check("flnb.busy", 32'(MduBusy), 32'd0);
    mfCheck("flnb.lo", 0);

    for (int i = 0; i < 40; i++) begin
      idle();
      ALUControlE = 4'($urandom_range(0, 15));
      RD1E = $urandom; RD2E = $urandom; SignImmE = $urandom; ResultW = $urandom;
      shamtE = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      if (!prevValid && ForwardAE == 2'b10) ForwardAE = 2'b00;
      if (!prevValid && ForwardBE == 2'b10) ForwardBE = 2'b00;
      ALUSrcE = 1'($urandom); RegDstE = 1'($urandom);
      RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom); MemWriteE = 1'($urandom);
      RtE = 5'($urandom); RdE = 5'($urandom);
      FlushE = ($urandom_range(0, 7) == 0);
      stepCheck($sformatf("alu%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      if (rop >= 3'd5) mtIssue($sformatf("rmt%0d", i), rop == 3'd5, ra);
      else mduIssue($sformatf("rmdu%0d", i), rop, ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        mfCheck($sformatf("rmdu%0d.lo", i), 0);
        mfCheck($sformatf("rmdu%0d.hi", i), 1);
      end
    end
    mfCheck("rmdu.lo", 0); mfCheck("rmdu.hi", 1);

    // Asynchronous reset in busy cycle 10 of a divide
    mtIssue("prehi", 1, 32'hA5A50001);
    mtIssue("prelo", 0, 32'h5A5A0002);
    mduIssue("rstdiv", 3'd3, 32'h7FFF0000, 32'd3);
    idle(); RegWriteE = 1; MemWriteE = 1; RD1E = 5; RD2E = 6; RtE = 5'd9;
    repeat (9) tick;
    check("rst2.preBusy", 32'(MduBusy), 32'd1);
    check("rst2.preCtl", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'd5);
    reset_n = 0;
    #1;
    check("rst2.busy", 32'(MduBusy), 32'd0);
    check("rst2.ctlM", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'd0);
    check("rst2.aluM", ALUOutM, 32'd0);
    check("rst2.wdatM", WriteDataM, 32'd0);
    check("rst2.wregM", 32'(WriteRegM), 32'd0);
    #1 reset_n = 1;
    hiM = 0; loM = 0; pendValid = 0; prevAlu = 0; prevValid = 1;
    mfCheck("rst2.hi", 1); mfCheck("rst2.lo", 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
